cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 6: number of functional-unit sources.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: cycles a valid source may wait before a forced grant.
REQ-003 SHALL have parameter PRIO_MASK [NUM_SRC-1:0], default 6'b010000: sources given fixed priority over round-robin (memory unit by default).
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port src_valid_i, input, NUM_SRC: per-source packet valid.
REQ-007 SHALL have port src_pkt_i, input, NUM_SRC x CDB_packet_t: per-source packet.
REQ-008 SHALL have port src_yumi_o, output, NUM_SRC: one-hot (or zero) consume strobe, same cycle as grant.
REQ-009 SHALL have port commit_pkt_i, input, CDB_packet_t: commit broadcast; valid when dest_ROB_entry != 0.
REQ-010 SHALL have port flush_i, input, 1: suppresses all source grants this cycle.
REQ-011 SHALL have port cdb_o, output, CDB_packet_t: registered broadcast; dest_ROB_entry == 0 means idle.
REQ-012 SHALL have port cdb_src_o, output, $clog2(NUM_SRC+1): winner index of the current cdb_o; value NUM_SRC denotes commit.

Function
REQ-013 SHALL grant per cycle by strict order: (1) commit valid; (2) lowest-index valid source whose starve counter == STARVE_LIMIT; (3) lowest-index valid source in PRIO_MASK; (4) round-robin among remaining valid sources starting at rr_ptr.
REQ-014 SHALL assert no src_yumi_o bit when the commit packet wins, when flush_i=1, or when no source is valid.
REQ-015 SHALL assert exactly one src_yumi_o bit, combinationally in the grant cycle, for a source winner.
REQ-016 SHALL register the winner packet into cdb_o on the next rising edge: latency exactly 1 cycle from grant.
REQ-017 SHALL load cdb_o with all fields zero and cdb_src_o 0 in a cycle with no winner.
REQ-018 SHALL forward the commit packet when flush_i=1 and commit is valid; otherwise SHALL load idle when flush_i=1.
REQ-019 SHALL set rr_ptr to (granted index + 1) mod NUM_SRC after any source grant (steps 2-4), wrapping NUM_SRC-1 -> 0; otherwise rr_ptr holds.
REQ-020 SHALL, per source: increment its starve counter when valid and not granted, saturating at STARVE_LIMIT; clear it when granted or when valid is low.
REQ-021 SHALL keep starve counters counting while commit or flush blocks grants.
REQ-022 SHALL require sources to hold valid and packet stable until yumi; SHALL not decode dest_ROB_entry of source packets.
REQ-023 SHALL support any NUM_SRC >= 2 and STARVE_LIMIT >= 1 without code change.

Reset
REQ-024 SHALL, while rst_n=0 at a clock edge: clear cdb_o to all zero, cdb_src_o to 0, rr_ptr to 0, and all starve counters to 0.
REQ-025 SHALL hold src_yumi_o at zero while rst_n=0, including reset asserted mid-transfer; the pending packet is not consumed.

Structure
REQ-026 SHALL use CDB_packet_t from the shared structs package; CDB_SRC_W (source-index width) and the default NUM_SRC SHALL be added there.
REQ-027 SHALL instantiate one sub-module, cdb_rr_pick: combinational masked round-robin picker (request vector, pointer -> one-hot grant).
REQ-028 SHALL be 120-400 lines of RTL total.

Verification
REQ-029 SHALL cover: commit dest_ROB_entry=4'h3 with sources 0 and 4 valid -> yumi=0, next cycle cdb_o=commit packet, cdb_src_o=6.
REQ-030 SHALL cover: sources 0,1,2 valid continuously, PRIO_MASK=0, rr_ptr=0 -> grants 0,1,2,0 on consecutive cycles; cdb_o follows one cycle later.
REQ-031 SHALL cover: source 4 (prio) valid every cycle with source 1 valid, STARVE_LIMIT=8 -> source 1 granted on the 9th cycle, counter cleared.
REQ-032 SHALL cover: source 5 granted with rr_ptr=5 -> rr_ptr wraps to 0; next round-robin grant is lowest valid index >= 0.
REQ-033 SHALL cover: flush_i=1 with source 2 valid and no commit -> yumi=0, next cdb_o idle, source 2 counter incremented.
REQ-034 SHALL cover: rst_n=0 for one cycle while source 3 valid and cdb_o busy -> cdb_o zero, yumi=0, rr_ptr=0; source 3 granted the first cycle after release.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared structures for the common data bus (CDB).
//   CDB_packet_t : broadcast packet; dest_ROB_entry == 0 marks an idle/invalid
//                  packet.
//   CDB_NUM_SRC  : default number of functional-unit sources on the bus.
//   CDB_SRC_W    : width of a winner index that can also encode "commit"
//                  (value CDB_NUM_SRC).
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

   localparam int CDB_ROB_W   = 4;
   localparam int CDB_DATA_W  = 32;
   localparam int CDB_NUM_SRC = 6;
   localparam int CDB_SRC_W   = $clog2(CDB_NUM_SRC + 1);

   typedef struct packed {
      logic [CDB_ROB_W-1:0]  dest_ROB_entry;
      logic [CDB_DATA_W-1:0] value;
      logic                  exc;
   } CDB_packet_t;

endpackage

// File: rtl/cdb_rr_pick.sv
// -----------------------------------------------------------------------------
// cdb_rr_pick
// Combinational masked round-robin picker.
//   req : request vector, one bit per source
//   ptr : index where the round-robin search starts
//   gnt : one-hot grant (all zero when req is zero)
// The lowest requesting index at or above ptr wins; if none exists the search
// wraps and the lowest requesting index overall wins.
// -----------------------------------------------------------------------------
module cdb_rr_pick #(
   parameter int N     = 6,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt
);

   logic [N-1:0] upper_req_s;
   logic [N-1:0] upper_gnt_s;
   logic [N-1:0] any_gnt_s;

   // Lowest-index pick in the masked (>= ptr) half and in the full vector.
   always_comb begin
      upper_req_s = {N{1'b0}};
      upper_gnt_s = {N{1'b0}};
      any_gnt_s   = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         upper_req_s[i] = req[i] && (i >= int'(ptr));
      end
      // Descending scan: the last hit written is the lowest index.
      for (int i = N - 1; i >= 0; i--) begin
         upper_gnt_s = upper_req_s[i] ? (N'(1) << i) : upper_gnt_s;
         any_gnt_s   = req[i]         ? (N'(1) << i) : any_gnt_s;
      end
      gnt = (|upper_req_s) ? upper_gnt_s : any_gnt_s;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Arbitrates the common data bus between a commit broadcast and NUM_SRC
// functional-unit sources, and registers the winner onto the bus.
//   clk, rst_n    : clock, synchronous active-low reset
//   src_valid_i   : per-source packet valid (held until yumi)
//   src_pkt_i     : per-source packet
//   src_yumi_o    : one-hot consume strobe, combinational in the grant cycle
//   commit_pkt_i  : commit broadcast, valid when dest_ROB_entry != 0
//   flush_i       : blocks all source grants this cycle
//   cdb_o         : registered broadcast (dest_ROB_entry == 0 is idle)
//   cdb_src_o     : winner index of cdb_o; NUM_SRC denotes commit
// Grant order: commit, starved source, fixed-priority source, round-robin.
// -----------------------------------------------------------------------------
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int                 NUM_SRC      = CDB_NUM_SRC,
   parameter int                 STARVE_LIMIT = 8,
   parameter logic [NUM_SRC-1:0] PRIO_MASK    = NUM_SRC'(6'b010000)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_SRC-1:0]           src_valid_i,
   input  CDB_packet_t                  src_pkt_i [NUM_SRC],
   output logic [NUM_SRC-1:0]           src_yumi_o,
   input  CDB_packet_t                  commit_pkt_i,
   input  logic                         flush_i,
   output CDB_packet_t                  cdb_o,
   output logic [$clog2(NUM_SRC+1)-1:0] cdb_src_o
);

   localparam int               SRC_W   = $clog2(NUM_SRC + 1);
   localparam int               PTR_W   = $clog2(NUM_SRC);
   localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic                 commit_vld_s;
   logic                 block_s;
   logic [NUM_SRC-1:0]   starve_req_s;
   logic [NUM_SRC-1:0]   prio_req_s;
   logic [NUM_SRC-1:0]   rr_gnt_s;
   logic [PTR_W-1:0]     starve_idx_s;
   logic [PTR_W-1:0]     prio_idx_s;
   logic [PTR_W-1:0]     rr_idx_s;
   logic [PTR_W-1:0]     win_idx_s;
   logic                 win_vld_s;
   logic [PTR_W-1:0]     rr_ptr_r;
   logic [CNT_W-1:0]     starve_cnt_r [NUM_SRC];

   cdb_rr_pick #(
      .N     (NUM_SRC),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req (src_valid_i),
      .ptr (rr_ptr_r),
      .gnt (rr_gnt_s)
   );

   // Winner selection and the combinational consume strobe.
   always_comb begin
      commit_vld_s = (commit_pkt_i.dest_ROB_entry != {CDB_ROB_W{1'b0}});
      // Reset is folded in so a source is never consumed while rst_n is low.
      block_s      = commit_vld_s || flush_i || !rst_n;
      starve_req_s = {NUM_SRC{1'b0}};
      prio_req_s   = src_valid_i & PRIO_MASK;
      starve_idx_s = {PTR_W{1'b0}};
      prio_idx_s   = {PTR_W{1'b0}};
      rr_idx_s     = {PTR_W{1'b0}};
      src_yumi_o   = {NUM_SRC{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         starve_req_s[i] = src_valid_i[i] && (starve_cnt_r[i] == CNT_MAX);
      end
      // Descending scan leaves the lowest matching index in each *_idx_s.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         starve_idx_s = starve_req_s[i] ? PTR_W'(i) : starve_idx_s;
         prio_idx_s   = prio_req_s[i]   ? PTR_W'(i) : prio_idx_s;
         rr_idx_s     = rr_gnt_s[i]     ? PTR_W'(i) : rr_idx_s;
      end
      if (|starve_req_s) begin
         win_idx_s = starve_idx_s;
      end else if (|prio_req_s) begin
         win_idx_s = prio_idx_s;
      end else begin
         win_idx_s = rr_idx_s;
      end
      win_vld_s = (|src_valid_i) && !block_s;
      for (int i = 0; i < NUM_SRC; i++) begin
         src_yumi_o[i] = win_vld_s && (win_idx_s == PTR_W'(i));
      end
   end

   // Bus output register, round-robin pointer and starvation counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cdb_o     <= '0;
         cdb_src_o <= {SRC_W{1'b0}};
         rr_ptr_r  <= {PTR_W{1'b0}};
         for (int i = 0; i < NUM_SRC; i++) begin
            starve_cnt_r[i] <= {CNT_W{1'b0}};
         end
      end else begin
         // Commit wins even under flush.
         if (commit_vld_s) begin
            cdb_o     <= commit_pkt_i;
            cdb_src_o <= SRC_W'(NUM_SRC);
         end else if (win_vld_s) begin
            cdb_o     <= src_pkt_i[win_idx_s];
            cdb_src_o <= SRC_W'(win_idx_s);
         end else begin
            cdb_o     <= '0;
            cdb_src_o <= {SRC_W{1'b0}};
         end
         if (win_vld_s) begin
            rr_ptr_r <= (win_idx_s == PTR_W'(NUM_SRC - 1)) ? {PTR_W{1'b0}}
                                                            : win_idx_s + PTR_W'(1);
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
         // Counters keep running while commit or flush hold the bus.
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!src_valid_i[i] || src_yumi_o[i]) begin
               starve_cnt_r[i] <= {CNT_W{1'b0}};
            end else if (starve_cnt_r[i] != CNT_MAX) begin
               starve_cnt_r[i] <= starve_cnt_r[i] + CNT_W'(1);
            end else begin
               starve_cnt_r[i] <= starve_cnt_r[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed scoreboard bench for cdb_arbiter (default parameters: 6 sources,
// STARVE_LIMIT 8, source 4 fixed priority). Stimulus checks the combinational
// yumi and queues the hand-computed bus value; the monitor compares cdb_o and
// cdb_src_o one cycle later.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N = 6;

   typedef struct {
      CDB_packet_t pkt;
      logic [2:0]  src;
      string       tag;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  src_valid;
   CDB_packet_t   src_pkt [N];
   logic [N-1:0]  src_yumi;
   CDB_packet_t   commit_pkt;
   logic          flush;
   CDB_packet_t   cdb;
   logic [2:0]    cdb_src;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   cdb_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .src_valid_i  (src_valid),
      .src_pkt_i    (src_pkt),
      .src_yumi_o   (src_yumi),
      .commit_pkt_i (commit_pkt),
      .flush_i      (flush),
      .cdb_o        (cdb),
      .cdb_src_o    (cdb_src)
   );

   function automatic CDB_packet_t src_pkt_of(input int i);
      CDB_packet_t p;
      p.dest_ROB_entry = 4'(i + 1);
      p.value          = 32'hA5A5_0000 + 32'(i);
      p.exc            = 1'(i % 2);
      return p;
   endfunction

   function automatic CDB_packet_t commit_pkt_of(input logic [3:0] d);
      CDB_packet_t p;
      p.dest_ROB_entry = d;
      p.value          = 32'hC0DE_0000 | {28'h0000000, d};
      p.exc            = 1'b0;
      return p;
   endfunction

   // One cycle of stimulus; exp_src: -1 idle, N commit, otherwise source index.
   task automatic step(input logic rst, input logic [5:0] vld, input logic [3:0] cdest,
                       input logic fl, input logic [5:0] exp_yumi, input int exp_src,
                       input string tag);
      exp_t e;
      @(posedge clk);
      #2;
      rst_n      = rst;
      src_valid  = vld;
      commit_pkt = commit_pkt_of(cdest);
      flush      = fl;
      #1;
      tests++;
      if (src_yumi !== exp_yumi) begin
         fails++;
         $display("FAIL %s yumi: got %b expected %b", tag, src_yumi, exp_yumi);
      end
      if (exp_src < 0) begin
         e.pkt = '0;
         e.src = 3'd0;
      end else if (exp_src == N) begin
         e.pkt = commit_pkt_of(cdest);
         e.src = 3'd6;
      end else begin
         e.pkt = src_pkt_of(exp_src);
         e.src = 3'(exp_src);
      end
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   // Monitor: compare the registered bus against the queued expectation.
   initial begin
      exp_t m;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            tests++;
            if (cdb !== m.pkt || cdb_src !== m.src) begin
               fails++;
               $display("FAIL %s cdb: got pkt=%h src=%0d expected pkt=%h src=%0d",
                        m.tag, cdb, cdb_src, m.pkt, m.src);
            end
         end
      end
   end

   initial begin
      rst_n      = 1'b0;
      src_valid  = 6'b000000;
      flush      = 1'b0;
      commit_pkt = commit_pkt_of(4'h0);
      for (int i = 0; i < N; i++) begin
         src_pkt[i] = src_pkt_of(i);
      end

      step(1'b0, 6'b000000, 4'h0, 1'b0, 6'b000000, -1, "reset0");
      step(1'b0, 6'b000000, 4'h0, 1'b0, 6'b000000, -1, "reset1");

      // Round-robin among 0,1,2 from rr_ptr 0.
      step(1'b1, 6'b000111, 4'h0, 1'b0, 6'b000001, 0, "rr_g0");
      step(1'b1, 6'b000111, 4'h0, 1'b0, 6'b000010, 1, "rr_g1");
      step(1'b1, 6'b000111, 4'h0, 1'b0, 6'b000100, 2, "rr_g2");
      step(1'b1, 6'b000111, 4'h0, 1'b0, 6'b000001, 0, "rr_g0b");
      step(1'b1, 6'b000000, 4'h0, 1'b0, 6'b000000, -1, "idle_a");

      // Commit beats sources; then prio source 4; then wrap from rr_ptr 5.
      step(1'b1, 6'b010001, 4'h3, 1'b0, 6'b000000, N, "commit3");
      step(1'b1, 6'b010001, 4'h0, 1'b0, 6'b010000, 4, "prio4");
      step(1'b1, 6'b100001, 4'h0, 1'b0, 6'b100000, 5, "src5_ptr5");
      step(1'b1, 6'b000011, 4'h0, 1'b0, 6'b000001, 0, "wrap_g0");
      step(1'b1, 6'b000000, 4'h0, 1'b0, 6'b000000, -1, "idle_b");

      // Flush alone idles; flush with commit forwards commit.
      step(1'b1, 6'b000100, 4'h0, 1'b1, 6'b000000, -1, "flush");
      step(1'b1, 6'b000100, 4'h5, 1'b1, 6'b000000, N, "flush_commit");
      step(1'b1, 6'b000100, 4'h0, 1'b0, 6'b000100, 2, "after_flush");
      step(1'b1, 6'b000000, 4'h0, 1'b0, 6'b000000, -1, "idle_c");

      // Starvation of source 1 against prio source 4; flush at c3 and commit
      // at c5 must not stop its counter, so it wins at c9 and again at c18.
      for (int c = 1; c <= 18; c++) begin
         if (c == 3) begin
            step(1'b1, 6'b010010, 4'h0, 1'b1, 6'b000000, -1, "starve_flush");
         end else if (c == 5) begin
            step(1'b1, 6'b010010, 4'h7, 1'b0, 6'b000000, N, "starve_commit");
         end else if (c == 9 || c == 18) begin
            step(1'b1, 6'b010010, 4'h0, 1'b0, 6'b000010, 1, "starve_g1");
         end else begin
            step(1'b1, 6'b010010, 4'h0, 1'b0, 6'b010000, 4, "starve_g4");
         end
      end
      step(1'b1, 6'b000000, 4'h0, 1'b0, 6'b000000, -1, "idle_d");

      // Twelve blocked cycles: counters must saturate, so source 1 (starved,
      // lower index) beats prio source 4 on release.
      for (int c = 0; c < 12; c++) begin
         step(1'b1, 6'b010010, 4'h2, 1'b0, 6'b000000, N, "sat_commit");
      end
      step(1'b1, 6'b010010, 4'h0, 1'b0, 6'b000010, 1, "sat_g1");
      step(1'b1, 6'b010000, 4'h0, 1'b0, 6'b010000, 4, "sat_g4");

      // Mid-stream reset with source 3 pending and bus busy; rr_ptr was 5.
      step(1'b0, 6'b001000, 4'h0, 1'b0, 6'b000000, -1, "rst_mid");
      step(1'b1, 6'b101000, 4'h0, 1'b0, 6'b001000, 3, "post_rst_g3");
      step(1'b1, 6'b100000, 4'h0, 1'b0, 6'b100000, 5, "post_rst_g5");
      step(1'b1, 6'b000000, 4'h0, 1'b0, 6'b000000, -1, "idle_end");

      @(posedge clk);
      #2;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
